fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the in-order pipeline. It tracks pending register writes across DEPTH downstream stages in an internal tag shift register.
- It forwards the youngest matching result to each of NUM_SRC decode-stage operands.
- When a source depends on a load whose data is not yet available, it stalls decode and inserts bubbles.
- It sits between the decode/register-file read and the EX operand latches.

---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_hazard_unit_if.sv | 43 ++++
 rtl/fwd_src_select.sv | 39 +++
 rtl/fwd_hazard_unit.sv | 101 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared tag type, bubble constant and default widths for the forwarding unit
package fwd_pkg;

   localparam int FWD_IDX_W      = 4;
   localparam int FWD_DATA_W     = 32;
   localparam int FWD_NUM_SRC    = 2;
   localparam int FWD_DEPTH      = 3;
   localparam int FWD_LOAD_STAGE = 1;

   // One pending register write tracked per downstream stage.
   typedef struct packed {
      logic                 valid;
      logic                 wr_en;
      logic                 is_load;
      logic [FWD_IDX_W-1:0] idx;
   } fwd_tag_t;

   localparam fwd_tag_t BUBBLE_TAG = '0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - decode/forwarding bus; FWD_PERF_CNT_EN adds counter outputs
interface fwd_hazard_unit_if
   import fwd_pkg::*;
#(
   parameter int REG_INDEX_BIT_WIDTH = FWD_IDX_W,
   parameter int bitwidth            = FWD_DATA_W,
   parameter int NUM_SRC             = FWD_NUM_SRC,
   parameter int DEPTH               = FWD_DEPTH
);
   logic                                   id_valid;
   logic [NUM_SRC*REG_INDEX_BIT_WIDTH-1:0] id_src_idx;
   logic [NUM_SRC*bitwidth-1:0]            id_src_data;
   logic [REG_INDEX_BIT_WIDTH-1:0]         id_dst_idx;
   logic                                   id_wr_en;
   logic                                   id_is_load;
   logic                                   flush;
   logic [DEPTH*bitwidth-1:0]              stage_data;
   logic [NUM_SRC*bitwidth-1:0]            fwd_data;
   logic [NUM_SRC-1:0]                     fwd_hit;
   logic                                   stall;
`ifdef FWD_PERF_CNT_EN
   logic [31:0]                            stall_cycles;
   logic [31:0]                            fwd_count;

   modport master (
      output id_valid, id_src_idx, id_src_data, id_dst_idx, id_wr_en, id_is_load, flush, stage_data,
      input  fwd_data, fwd_hit, stall, stall_cycles, fwd_count
   );
   modport slave (
      input  id_valid, id_src_idx, id_src_data, id_dst_idx, id_wr_en, id_is_load, flush, stage_data,
      output fwd_data, fwd_hit, stall, stall_cycles, fwd_count
   );
`else
   modport master (
      output id_valid, id_src_idx, id_src_data, id_dst_idx, id_wr_en, id_is_load, flush, stage_data,
      input  fwd_data, fwd_hit, stall
   );
   modport slave (
      input  id_valid, id_src_idx, id_src_data, id_dst_idx, id_wr_en, id_is_load, flush, stage_data,
      output fwd_data, fwd_hit, stall
   );
`endif
endinterface

// File: rtl/fwd_src_select.sv
// rtl/fwd_src_select.sv - per-operand youngest-producer matcher and data mux
module fwd_src_select
   import fwd_pkg::*;
#(
   parameter int REG_INDEX_BIT_WIDTH = FWD_IDX_W,
   parameter int bitwidth            = FWD_DATA_W,
   parameter int DEPTH               = FWD_DEPTH,
   parameter int LOAD_STAGE          = FWD_LOAD_STAGE
) (
   input  fwd_tag_t [DEPTH-1:0]           tags,
   input  logic [DEPTH*bitwidth-1:0]      stage_data,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] src_idx,
   input  logic [bitwidth-1:0]            src_data,
   output logic [bitwidth-1:0]            data,
   output logic                           hit,
   output logic                           load_hazard
);

   // Walk oldest to youngest so the lowest matching stage has the last word.
   always_comb begin
      data        = src_data;
      hit         = 1'b0;
      load_hazard = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (tags[k].valid && tags[k].wr_en && tags[k].idx == src_idx) begin
            if (tags[k].is_load && k < LOAD_STAGE) begin
               data        = src_data;
               hit         = 1'b0;
               load_hazard = 1'b1;
            end else begin
               data        = stage_data[k*bitwidth +: bitwidth];
               hit         = 1'b1;
               load_hazard = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding and load-use stall unit; FWD_PERF_CNT_EN adds perf counters
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_INDEX_BIT_WIDTH = FWD_IDX_W,
   parameter int bitwidth            = FWD_DATA_W,
   parameter int NUM_SRC             = FWD_NUM_SRC,
   parameter int DEPTH               = FWD_DEPTH,
   parameter int LOAD_STAGE          = FWD_LOAD_STAGE
) (
   input logic              clk,
   input logic              rst_n,
   fwd_hazard_unit_if.slave bus
);

   fwd_tag_t [DEPTH-1:0]        tags;
   fwd_tag_t [DEPTH-1:0]        tags_next;
   logic [NUM_SRC*bitwidth-1:0] fwd_data;
   logic [NUM_SRC-1:0]          fwd_hit;
   logic [NUM_SRC-1:0]          load_haz;
   logic                        stall;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_select #(
         .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
         .bitwidth           (bitwidth),
         .DEPTH              (DEPTH),
         .LOAD_STAGE         (LOAD_STAGE)
      ) u_sel (
         .tags       (tags),
         .stage_data (bus.stage_data),
         .src_idx    (bus.id_src_idx[i*REG_INDEX_BIT_WIDTH +: REG_INDEX_BIT_WIDTH]),
         .src_data   (bus.id_src_data[i*bitwidth +: bitwidth]),
         .data       (fwd_data[i*bitwidth +: bitwidth]),
         .hit        (fwd_hit[i]),
         .load_hazard(load_haz[i])
      );
   end

   assign stall        = bus.id_valid && !bus.flush && (|load_haz);
   assign bus.stall    = stall;
   assign bus.fwd_data = fwd_data;
   assign bus.fwd_hit  = fwd_hit;

   // Flush kills both decode and the EX entry; stall only bubbles decode.
   always_comb begin
      tags_next = tags;
      for (int k = DEPTH - 1; k > 0; k--) begin
         tags_next[k] = tags[k-1];
      end
      tags_next[0] = '{valid:   bus.id_valid,
                       wr_en:   bus.id_wr_en,
                       is_load: bus.id_is_load,
                       idx:     bus.id_dst_idx};
      if (bus.flush) begin
         tags_next[0]       = BUBBLE_TAG;
         tags_next[1].valid = 1'b0;
      end else if (stall) begin
         tags_next[0] = BUBBLE_TAG;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tags <= '0;
      end else begin
         tags <= tags_next;
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] fwd_count_q;
   logic [31:0] hit_cnt;
   logic [32:0] fwd_sum;

   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         hit_cnt = hit_cnt + 32'(fwd_hit[i]);
      end
      fwd_sum = {1'b0, fwd_count_q} + {1'b0, hit_cnt};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
         fwd_count_q    <= '0;
      end else begin
         if (stall && stall_cycles_q != '1) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         fwd_count_q <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
   end

   assign bus.stall_cycles = stall_cycles_q;
   assign bus.fwd_count    = fwd_count_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed bench for fwd_hazard_unit with LOAD_STAGE 1 and 2 instances
module tb_fwd_hazard_unit;
   import fwd_pkg::*;

   localparam int W  = 4;
   localparam int B  = 32;
   localparam int NS = 2;
   localparam int D  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic             id_valid, id_wr_en, id_is_load, flush;
   logic [NS*W-1:0]  id_src_idx;
   logic [NS*B-1:0]  id_src_data;
   logic [W-1:0]     id_dst_idx;
   logic [D*B-1:0]   stage_data;

   fwd_hazard_unit_if #(.REG_INDEX_BIT_WIDTH(W), .bitwidth(B), .NUM_SRC(NS), .DEPTH(D)) bus1 ();
   fwd_hazard_unit_if #(.REG_INDEX_BIT_WIDTH(W), .bitwidth(B), .NUM_SRC(NS), .DEPTH(D)) bus2 ();

   assign bus1.id_valid = id_valid,       bus2.id_valid = id_valid;
   assign bus1.id_src_idx = id_src_idx,   bus2.id_src_idx = id_src_idx;
   assign bus1.id_src_data = id_src_data, bus2.id_src_data = id_src_data;
   assign bus1.id_dst_idx = id_dst_idx,   bus2.id_dst_idx = id_dst_idx;
   assign bus1.id_wr_en = id_wr_en,       bus2.id_wr_en = id_wr_en;
   assign bus1.id_is_load = id_is_load,   bus2.id_is_load = id_is_load;
   assign bus1.flush = flush,             bus2.flush = flush;
   assign bus1.stage_data = stage_data,   bus2.stage_data = stage_data;

   fwd_hazard_unit #(.REG_INDEX_BIT_WIDTH(W), .bitwidth(B), .NUM_SRC(NS), .DEPTH(D), .LOAD_STAGE(1))
      u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   fwd_hazard_unit #(.REG_INDEX_BIT_WIDTH(W), .bitwidth(B), .NUM_SRC(NS), .DEPTH(D), .LOAD_STAGE(2))
      u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   logic [NS*B-1:0] dd [2];
   logic [NS-1:0]   dh [2];
   logic            ds [2];
   assign dd[0] = bus1.fwd_data, dd[1] = bus2.fwd_data;
   assign dh[0] = bus1.fwd_hit,  dh[1] = bus2.fwd_hit;
   assign ds[0] = bus1.stall,    ds[1] = bus2.stall;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: what each stage holds, in terms of the instruction that entered it.
   typedef struct {bit v; bit w; bit l; int idx;} mtag_t;
   mtag_t   m [2][D];
   longint  sc [2];
   longint  fc [2];

   function automatic int ls_of(input int u);
      return u + 1;
   endfunction

   function automatic void eval_src(input int u, input int s, output logic [B-1:0] d,
                                    output bit h, output bit hz);
      bit found = 0;
      d  = id_src_data[s*B +: B];
      h  = 0;
      hz = 0;
      for (int k = 0; k < D; k++) begin
         if (!found && m[u][k].v && m[u][k].w && m[u][k].idx == int'(id_src_idx[s*W +: W])) begin
            found = 1;
            if (m[u][k].l && k < ls_of(u)) hz = 1;
            else begin
               d = stage_data[k*B +: B];
               h = 1;
            end
         end
      end
   endfunction

   function automatic bit model_stall(input int u);
      logic [B-1:0] d;
      bit h, hz, any;
      any = 0;
      for (int s = 0; s < NS; s++) begin
         eval_src(u, s, d, h, hz);
         any |= hz;
      end
      return id_valid && !flush && any;
   endfunction

   function automatic int model_hits(input int u);
      logic [B-1:0] d;
      bit h, hz;
      int n = 0;
      for (int s = 0; s < NS; s++) begin
         eval_src(u, s, d, h, hz);
         n += int'(h);
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < D; k++) m[u][k] = '{0, 0, 0, 0};
            sc[u] = 0;
            fc[u] = 0;
         end
      end else begin
         for (int u = 0; u < 2; u++) begin
            bit st;
            st = model_stall(u);
            if (st) sc[u]++;
            fc[u] += model_hits(u);
            for (int k = D - 1; k > 0; k--) m[u][k] = m[u][k-1];
            if (flush) begin
               m[u][1].v = 0;
               m[u][0]   = '{0, 0, 0, 0};
            end else if (st) begin
               m[u][0] = '{0, 0, 0, 0};
            end else begin
               m[u][0] = '{id_valid, id_wr_en, id_is_load, int'(id_dst_idx)};
            end
         end
      end
   end

   always @(negedge clk) begin : cmp
      logic [NS*B-1:0] ed;
      logic [NS-1:0]   eh;
      logic [B-1:0]    d;
      bit              h, hz;
      for (int u = 0; u < 2; u++) begin
         for (int s = 0; s < NS; s++) begin
            eval_src(u, s, d, h, hz);
            ed[s*B +: B] = d;
            eh[s]        = h;
         end
         chk($sformatf("model_data_u%0d", u), 64'(dd[u]), 64'(ed));
         chk($sformatf("model_hit_u%0d", u), 64'(dh[u]), 64'(eh));
         chk($sformatf("model_stall_u%0d", u), 64'(ds[u]), 64'(model_stall(u)));
      end
`ifdef FWD_PERF_CNT_EN
      chk("model_stall_cycles_u0", 64'(bus1.stall_cycles), 64'(sc[0]));
      chk("model_stall_cycles_u1", 64'(bus2.stall_cycles), 64'(sc[1]));
      chk("model_fwd_count_u0", 64'(bus1.fwd_count), 64'(fc[0]));
      chk("model_fwd_count_u1", 64'(bus2.fwd_count), 64'(fc[1]));
`endif
   end

   task automatic issue(input bit v, input int s0, input int s1, input int dst,
                        input bit wr, input bit ld, input bit fl);
      @(posedge clk);
      #1;
      id_valid   = v;
      id_src_idx = {W'(s1), W'(s0)};
      id_dst_idx = W'(dst);
      id_wr_en   = wr;
      id_is_load = ld;
      flush      = fl;
   endtask

   task automatic nop();
      issue(0, 15, 15, 0, 0, 0, 0);
   endtask

   localparam logic [NS*B-1:0] SRC = {32'h0000_00B1, 32'h0000_00A0};

   initial begin
      id_valid    = 0;
      id_wr_en    = 0;
      id_is_load  = 0;
      flush       = 0;
      id_src_idx  = '1;
      id_dst_idx  = '0;
      id_src_data = SRC;
      stage_data  = {32'h0000_0002, 32'h0000_0033, 32'h0000_0001};
      #1 rst_n = 0;
      #2;
      chk("reset_stall", 64'(bus1.stall), 64'd0);
      chk("reset_hit", 64'(bus1.fwd_hit), 64'd0);
      chk("reset_data", 64'(bus1.fwd_data), 64'(SRC));
      @(posedge clk);
      #1 rst_n = 1;
      nop(); nop(); nop();

      // No hazard: ADD r1 in EX, decode reads r2 with zero register data.
      issue(1, 5, 6, 1, 1, 0, 0);
      issue(1, 2, 7, 9, 0, 0, 0);
      id_src_data = '0;
      #2;
      chk("t1_hit", 64'(bus1.fwd_hit), 64'd0);
      chk("t1_data", 64'(bus1.fwd_data), 64'd0);
      chk("t1_stall", 64'(bus1.stall), 64'd0);
      id_src_data = SRC;

      // EX-to-decode forward of r0.
      issue(1, 8, 9, 0, 1, 0, 0);
      issue(1, 0, 10, 9, 0, 0, 0);
      #2;
      chk("t2_hit", 64'(bus1.fwd_hit), 64'b01);
      chk("t2_data0", 64'(bus1.fwd_data[31:0]), 64'h1);

      // r0 pending in EX and WB: youngest (EX) wins.
      issue(1, 8, 9, 0, 1, 0, 0);
      nop();
      issue(1, 8, 9, 0, 1, 0, 0);
      issue(1, 0, 10, 9, 0, 0, 0);
      #2;
      chk("t3_prio_ex", 64'(bus1.fwd_data[31:0]), 64'h1);
      issue(1, 8, 9, 0, 1, 0, 0);
      nop(); nop();
      issue(1, 0, 10, 9, 0, 0, 0);
      #2;
      chk("t3_wb_only", 64'(bus1.fwd_data[31:0]), 64'h2);

      // Store with idx r0 in MEM does not forward.
      issue(1, 1, 2, 0, 0, 0, 0);
      nop();
      issue(1, 0, 10, 9, 0, 0, 0);
      #2;
      chk("t4_hit", 64'(bus1.fwd_hit), 64'd0);
      chk("t4_data", 64'(bus1.fwd_data), 64'(SRC));

      // Both sources from different stages: r0 from WB, r1 from EX.
      issue(1, 8, 9, 0, 1, 0, 0);
      nop();
      issue(1, 8, 9, 1, 1, 0, 0);
      issue(1, 0, 1, 9, 0, 0, 0);
      #2;
      chk("t7_hit", 64'(bus1.fwd_hit), 64'b11);
      chk("t7_data", 64'(bus1.fwd_data), {32'h1, 32'h2});

      // Own destination equal to own source is not a match.
      issue(1, 5, 5, 5, 1, 0, 0);
      #2;
      chk("self_hit", 64'(bus1.fwd_hit), 64'd0);
      nop(); nop(); nop();

      // Load-use on src1: one stall with LOAD_STAGE=1, two with LOAD_STAGE=2.
      issue(1, 6, 7, 3, 1, 1, 0);
      issue(1, 9, 3, 8, 0, 0, 0);
      #2;
      chk("t5_stall1_c0", 64'(bus1.stall), 64'd1);
      chk("t5_stall2_c0", 64'(bus2.stall), 64'd1);
      chk("t5_hit1_c0", 64'(bus1.fwd_hit), 64'd0);
      chk("t5_data1_c0", 64'(bus1.fwd_data), 64'(SRC));
      issue(1, 9, 3, 8, 0, 0, 0);
      #2;
      chk("t5_stall1_c1", 64'(bus1.stall), 64'd0);
      chk("t5_hit1_c1", 64'(bus1.fwd_hit), 64'b10);
      chk("t5_data1_c1", 64'(bus1.fwd_data[63:32]), 64'h33);
      chk("t5_stall2_c1", 64'(bus2.stall), 64'd1);
      issue(1, 9, 3, 8, 0, 0, 0);
      #2;
      chk("t5_stall2_c2", 64'(bus2.stall), 64'd0);
      chk("t5_hit2_c2", 64'(bus2.fwd_hit), 64'b10);
      chk("t5_data2_c2", 64'(bus2.fwd_data[63:32]), 64'h2);
`ifdef FWD_PERF_CNT_EN
      chk("t5_stall_cycles2", 64'(bus2.stall_cycles), 64'd2);
`endif
      nop(); nop(); nop();

      // Flush beats stall and kills the load in flight.
      issue(1, 6, 7, 3, 1, 1, 0);
      issue(1, 3, 9, 8, 0, 0, 1);
      #2;
      chk("flush_stall1", 64'(bus1.stall), 64'd0);
      chk("flush_stall2", 64'(bus2.stall), 64'd0);
      issue(1, 3, 9, 8, 0, 0, 0);
      #2;
      chk("flush_after_hit", 64'(bus1.fwd_hit), 64'd0);
      chk("flush_after_stall", 64'(bus2.stall), 64'd0);

      // Reset in the middle of a load-use stall.
      issue(1, 6, 7, 4, 1, 1, 0);
      issue(1, 4, 4, 8, 0, 0, 0);
      #2;
      chk("rst_pre_stall", 64'(bus1.stall), 64'd1);
      #1 rst_n = 0;
      #1;
      chk("rst_mid_stall1", 64'(bus1.stall), 64'd0);
      chk("rst_mid_stall2", 64'(bus2.stall), 64'd0);
      chk("rst_mid_hit", 64'(bus1.fwd_hit), 64'd0);
      chk("rst_mid_data", 64'(bus1.fwd_data), 64'(SRC));
`ifdef FWD_PERF_CNT_EN
      chk("rst_stall_cycles", 64'(bus2.stall_cycles), 64'd0);
`endif
      @(posedge clk);
      #1 rst_n = 1;
      nop(); nop();
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
